output_arbiter: RTL

- Per-output-port merge stage of the mesh router. It collects up to CHANNEL_NUMBER AXI-Stream inputs, one from each input port's routing stage, into one output stream.
- It does packet-granular round-robin arbitration. A grant is held from the first beat to the TLAST beat, so packets never interleave.
- It sits between the routing demux fabric and the router's output link. It is the converging counterpart of the per-input demux.

---
 rtl/router_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/output_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared mesh-router definitions (channel indices, arbiter FSM).
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int CH_LOCAL = 0;
  localparam int CH_NORTH = 1;  // target_y < own
  localparam int CH_EAST  = 2;  // target_x > own
  localparam int CH_SOUTH = 3;  // target_y > own
  localparam int CH_WEST  = 4;  // target_x < own

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Rotating-priority picker; owns the round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import router_pkg::*;
#(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNEL_NUMBER-1:0]       req_i,
  input  logic                            advance_i,
  input  logic [CHANNEL_NUMBER_WIDTH-1:0] winner_i,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] pick_o,
  output logic                            any_req_o
);

  localparam int c_W = CHANNEL_NUMBER_WIDTH;

  logic [c_W-1:0] rr_ptr_q;
  logic [c_W-1:0] rr_ptr_d;
  logic [c_W-1:0] w_pick;

  function automatic logic [c_W-1:0] ring_idx(input logic [c_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= CHANNEL_NUMBER) s = s - CHANNEL_NUMBER;
    return c_W'(s);
  endfunction

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) rr_ptr_d = c_W'(rr_next(int'(winner_i), CHANNEL_NUMBER));
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  // Walk from the farthest offset back to the pointer so the nearest requester wins.
  always_comb begin
    w_pick = rr_ptr_q;
    for (int k = CHANNEL_NUMBER - 1; k >= 0; k--) begin
      if (req_i[ring_idx(rr_ptr_q, k)]) w_pick = ring_idx(rr_ptr_q, k);
    end
  end

  assign pick_o    = w_pick;
  assign any_req_o = |req_i;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_arbiter
// Description : Packet-granular round-robin merge of AXI-Stream inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module output_arbiter
  import router_pkg::*;
#(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int DEST_WIDTH           = 4,
  parameter int USER_WIDTH           = 4,
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1,
  parameter bit USE_LIGHT_STREAM     = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CHANNEL_NUMBER-1:0]            in_tvalid_i,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata_i,
  input  logic [CHANNEL_NUMBER-1:0]            in_tlast_i,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]   in_tid_i,
  input  logic [CHANNEL_NUMBER*DEST_WIDTH-1:0] in_tdest_i,
  input  logic [CHANNEL_NUMBER*USER_WIDTH-1:0] in_tuser_i,
  output logic [CHANNEL_NUMBER-1:0]            in_tready_o,
  output logic                                 out_tvalid_o,
  output logic [DATA_WIDTH-1:0]                out_tdata_o,
  output logic                                 out_tlast_o,
  output logic [ID_WIDTH-1:0]                  out_tid_o,
  output logic [DEST_WIDTH-1:0]                out_tdest_o,
  output logic [USER_WIDTH-1:0]                out_tuser_o,
  input  logic                                 out_tready_i,
  output logic [CHANNEL_NUMBER_WIDTH-1:0]      grant_o,
  output logic                                 busy_o
);

  localparam int c_W = CHANNEL_NUMBER_WIDTH;

  arb_state_t     state_q;
  logic [c_W-1:0] grant_q;

  logic [c_W-1:0] w_pick;
  logic           w_any_req;
  logic           w_locked;
  logic           w_tvalid;
  logic           w_tlast;
  logic           w_advance;
  logic [DATA_WIDTH-1:0] w_tdata;

  assign w_locked  = (state_q == LOCKED);
  assign w_advance = w_locked & w_tvalid & out_tready_i & w_tlast;

  rr_arbiter #(
    .CHANNEL_NUMBER       (CHANNEL_NUMBER),
    .CHANNEL_NUMBER_WIDTH (CHANNEL_NUMBER_WIDTH)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req_i     (in_tvalid_i),
    .advance_i (w_advance),
    .winner_i  (grant_q),
    .pick_o    (w_pick),
    .any_req_o (w_any_req)
  );

  // Grant is held from the first beat to the TLAST handshake; bubbles keep the lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_any_req) begin
            grant_q <= w_pick;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_advance) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_tvalid = 1'b0;
    w_tlast  = 1'b0;
    w_tdata  = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      if (w_locked && (grant_q == c_W'(c))) begin
        w_tvalid = in_tvalid_i[c];
        w_tlast  = in_tlast_i[c];
        w_tdata  = in_tdata_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    in_tready_o = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      in_tready_o[c] = w_locked & (grant_q == c_W'(c)) & out_tready_i;
    end
  end

  generate
    if (USE_LIGHT_STREAM) begin : g_light
      assign out_tid_o   = '0;
      assign out_tdest_o = '0;
      assign out_tuser_o = '0;
    end else begin : g_sideband
      logic [ID_WIDTH-1:0]   w_tid;
      logic [DEST_WIDTH-1:0] w_tdest;
      logic [USER_WIDTH-1:0] w_tuser;

      always_comb begin
        w_tid   = '0;
        w_tdest = '0;
        w_tuser = '0;
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
          if (w_locked && (grant_q == c_W'(c))) begin
            w_tid   = in_tid_i[c*ID_WIDTH +: ID_WIDTH];
            w_tdest = in_tdest_i[c*DEST_WIDTH +: DEST_WIDTH];
            w_tuser = in_tuser_i[c*USER_WIDTH +: USER_WIDTH];
          end
        end
      end

      assign out_tid_o   = w_tid;
      assign out_tdest_o = w_tdest;
      assign out_tuser_o = w_tuser;
    end
  endgenerate

  assign out_tvalid_o = w_tvalid;
  assign out_tdata_o  = w_tdata;
  assign out_tlast_o  = w_tlast;
  assign grant_o      = grant_q;
  assign busy_o       = w_locked;

endmodule : output_arbiter
`default_nettype wire
